handshake_width_down: RTL and testbench
=======================================

# handshake_width_down

Valid/ready width down-converter that sits directly downstream of the handshake_pipe_* register-slice stages. It accepts one IN_W-bit word per master-side handshake and replays it as RATIO = IN_W/OUT_W narrow beats on the slave side, with slave_last marking the final beat. It sustains one beat per cycle with no bubble between consecutive words.

## Interface
- IN_W, default 32: input word width.
- OUT_W, default 8: output beat width. IN_W must be an integer multiple of OUT_W, with RATIO >= 2; elaboration fails otherwise.
- LSB_FIRST, default 1: 1 sends bits [OUT_W-1:0] first; 0 sends the MSB slice first.
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- master_valid, input, 1: upstream word valid.
- master_data, input, IN_W: upstream word.
- master_ready, output, 1: block can accept a word this cycle.
- slave_valid, output, 1: beat valid.
- slave_data, output, OUT_W: current beat.
- slave_last, output, 1: current beat is the final beat of its word.
- slave_ready, input, 1: downstream accepts the beat.

## Operation
- State:
  - word register wreg (IN_W bits).
  - beat counter cnt, clog2(RATIO) bits.
  - full flag, which drives slave_valid.
- Definitions:
  - Handshakes are in_fire = master_valid & master_ready and out_fire = slave_valid & slave_ready.
  - last_beat = (cnt == RATIO-1).
- master_ready = !full | (slave_ready & last_beat). This is combinational from slave_ready and is the only combinational input-to-output path.
- slave_data = slice cnt of wreg when LSB_FIRST=1, or slice RATIO-1-cnt when LSB_FIRST=0.
- slave_last = full & last_beat.
- Per clock edge:
  - in_fire: wreg <= master_data, cnt <= 0, full <= 1. This takes priority over the out_fire update when both occur.
  - out_fire & !last_beat & !in_fire: cnt <= cnt+1.
  - out_fire & last_beat & !in_fire: full <= 0, cnt <= 0.
  - otherwise: hold.
- While slave_valid=1 and slave_ready=0, slave_data and slave_last hold stable. Valid never drops without a handshake.
- slave_valid does not depend combinationally on master_valid.
- Counter arithmetic wraps only through the explicit reset to 0. cnt never exceeds RATIO-1.

## Timing
- Reset values:
  - slave_valid=0, slave_last=0, slave_data=0 (wreg=0), cnt=0.
  - master_ready=1 once rst_n is high, because the block is empty.
- Latency: a word accepted at edge N presents beat 0 in the cycle after N. The final beat is presented after N+RATIO-1 at the earliest.
- Throughput: with slave_ready held at 1, a back-to-back word is accepted on the same edge that retires the last beat, giving RATIO beats per word and 0 bubble cycles.
- Simultaneous in_fire and last-beat out_fire: the old beat is retired and the new word is loaded on the same edge.
- Reset asserted mid-word: all state clears immediately (asynchronously). The partial word is discarded and no beat of it appears after reset release.
- Back-pressure: master_ready is low whenever full=1 and the last beat is not being retired this cycle.

## Structure
- Shared package handshake_pkg holds:
  - default width constants DATA_W=32 and BEAT_W=8.
  - a function computing clog2(RATIO) for sizing cnt.
- Single module, no sub-module.
- The output slice mux is a generate-selected indexed part-select on LSB_FIRST.
- Any handshake_pipe_* stage can be placed before or after this block unchanged, since the handshake rules match.

## Test plan
- Single word, LSB_FIRST=1, slave_ready=1:
  - master_data=0x44332211 -> beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles.
  - slave_last=1 only on 0x44.
  - master_ready=1 again in the 0x44 cycle.
- LSB_FIRST=0, same word -> beats 0x44, 0x33, 0x22, 0x11, with last on 0x11.
- Back-to-back words, master_valid=1 and slave_ready=1:
  - words 0xA3A2A1A0 then 0xB3B2B1B0 -> 8 beats on 8 consecutive cycles, no gap.
  - master_ready high only on beats 3 and 7.
- Stall mid-word:
  - drop slave_ready for 3 cycles while beat 0x22 is presented -> 0x22 and slave_last=0 held stable, cnt unchanged, master_ready=0.
  - resumes with 0x33 after slave_ready returns.
- Reset mid-word: pulse rst_n low after beat 0x11 is accepted -> slave_valid=0 immediately. The next accepted word 0x0000BEEF emits 0xEF, 0xBE, 0x00, 0x00 with no stale beat.
- Randomised:
  - 30 random words with random master_valid/slave_ready.
  - The scoreboard reassembles beats into words, compares them in order against the accepted words, and checks that every word ends with slave_last.
  - Timeout of 50 cycles after the master count reaches 30.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared width defaults and sizing helpers for the handshake_* blocks.
package handshake_pkg;

    localparam int DATA_W = 32;
    localparam int BEAT_W = 8;

    // Bits needed to count 0..ratio-1; never less than one bit.
    function automatic int cnt_width(input int ratio);
        int w;
        w = 1;
        while ((1 << w) < ratio) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/handshake_width_down.sv
// Valid/ready width down-converter: one IN_W word in, IN_W/OUT_W OUT_W-bit beats out.
module handshake_width_down
    import handshake_pkg::*;
#(
    parameter int IN_W      = DATA_W,
    parameter int OUT_W     = BEAT_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             master_valid,
    input  logic [IN_W-1:0]  master_data,
    output logic             master_ready,
    output logic             slave_valid,
    output logic [OUT_W-1:0] slave_data,
    output logic             slave_last,
    input  logic             slave_ready
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = cnt_width(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_param_check
        $fatal(1, "handshake_width_down: IN_W must be a multiple of OUT_W with ratio >= 2");
    end

    logic [IN_W-1:0]  r_wreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_full;

    logic             w_last_beat;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [CNT_W-1:0] w_sel;

    assign w_last_beat  = (r_cnt == LAST_CNT);
    // Ready may look through to slave_ready so a new word lands on the edge that retires the last beat.
    assign master_ready = !r_full || (slave_ready && w_last_beat);
    assign w_in_fire    = master_valid && master_ready;
    assign w_out_fire   = r_full && slave_ready;

    assign slave_valid  = r_full;
    assign slave_last   = r_full && w_last_beat;

    if (LSB_FIRST) begin : g_lsb_first
        assign w_sel = r_cnt;
    end else begin : g_msb_first
        assign w_sel = LAST_CNT - r_cnt;
    end

    assign slave_data = r_wreg[int'(w_sel) * OUT_W +: OUT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wreg <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (w_in_fire) begin
            r_wreg <= master_data;
            r_cnt  <= '0;
            r_full <= 1'b1;
        end else if (w_out_fire) begin
            if (w_last_beat) begin
                r_full <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_handshake_width_down.sv
// Scoreboard bench: an LSB-first and an MSB-first converter share one stimulus stream.
module tb_handshake_width_down;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        master_valid = 1'b0;
    logic [31:0] master_data = '0;
    logic        slave_ready = 1'b0;

    logic        mr_l, sv_l, sl_l;
    logic [7:0]  sd_l;
    logic        mr_m, sv_m, sl_m;
    logic [7:0]  sd_m;

    int checks = 0;
    int failures = 0;

    logic [31:0] wq_l[$];
    logic [31:0] wq_m[$];
    logic [31:0] acc_l = '0;
    logic [31:0] acc_m = '0;
    int          idx_l = 0;
    int          idx_m = 0;

    always #5 clk = ~clk;

    handshake_width_down #(.IN_W(32), .OUT_W(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .master_valid(master_valid), .master_data(master_data), .master_ready(mr_l),
        .slave_valid(sv_l), .slave_data(sd_l), .slave_last(sl_l), .slave_ready(slave_ready)
    );

    handshake_width_down #(.IN_W(32), .OUT_W(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n),
        .master_valid(master_valid), .master_data(master_data), .master_ready(mr_m),
        .slave_valid(sv_m), .slave_data(sd_m), .slave_last(sl_m), .slave_ready(slave_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // LSB-first scoreboard: reassemble beats, compare each word against the accepted order.
    always @(negedge clk) begin
        if (!rst_n) begin
            idx_l = 0;
            wq_l.delete();
        end else begin
            if (sv_l && slave_ready) begin
                acc_l[idx_l*8 +: 8] = sd_l;
                chk("lsb_last", {31'd0, sl_l}, {31'd0, idx_l == 3});
                if (idx_l == 3) begin
                    if (wq_l.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL lsb_spurious_word actual=%h expected=none", acc_l);
                    end else begin
                        chk("lsb_word", acc_l, wq_l.pop_front());
                    end
                    idx_l = 0;
                end else begin
                    idx_l++;
                end
            end
            if (master_valid && mr_l) wq_l.push_back(master_data);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            idx_m = 0;
            wq_m.delete();
        end else begin
            if (sv_m && slave_ready) begin
                acc_m[(3-idx_m)*8 +: 8] = sd_m;
                chk("msb_last", {31'd0, sl_m}, {31'd0, idx_m == 3});
                if (idx_m == 3) begin
                    if (wq_m.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL msb_spurious_word actual=%h expected=none", acc_m);
                    end else begin
                        chk("msb_word", acc_m, wq_m.pop_front());
                    end
                    idx_m = 0;
                end else begin
                    idx_m++;
                end
            end
            if (master_valid && mr_m) wq_m.push_back(master_data);
        end
    end

    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        master_valid = 1'b1;
        master_data  = w;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = mr_l;
            @(posedge clk);
            #1;
        end
        master_valid = 1'b0;
        chk("send_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            done = !sv_l && !sv_m && (wq_l.size() == 0) && (wq_m.size() == 0);
        end
        chk("drain_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        bit fired;
        int nsent;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, sv_l}, 32'd0);
        chk("rst_last", {31'd0, sl_l}, 32'd0);
        chk("rst_data", {24'd0, sd_l}, 32'd0);
        chk("rst_valid_msb", {31'd0, sv_m}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, mr_l}, 32'd1);

        // Single word at full rate: 4 consecutive beats, ready returns on the last
        slave_ready = 1'b1;
        send_word(32'h44332211);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("single_valid", {31'd0, sv_l}, 32'd1);
            chk("single_data", {24'd0, sd_l}, 32'h11 * (k + 1));
            chk("single_msb_data", {24'd0, sd_m}, 32'h11 * (4 - k));
            chk("single_ready", {31'd0, mr_l}, {31'd0, k == 3});
        end
        @(negedge clk);
        chk("single_idle", {31'd0, sv_l}, 32'd0);

        // Back-to-back words: 8 beats with no gap
        @(posedge clk);
        #1;
        master_valid = 1'b1;
        master_data  = 32'hA3A2A1A0;
        @(negedge clk);
        chk("b2b_ready0", {31'd0, mr_l}, 32'd1);
        @(posedge clk);
        #1 master_data = 32'hB3B2B1B0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b2b_valid", {31'd0, sv_l}, 32'd1);
            chk("b2b_ready", {31'd0, mr_l}, {31'd0, (k == 3) || (k == 7)});
            @(posedge clk);
            #1;
            if (k == 3) master_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", {31'd0, sv_l}, 32'd0);

        // Stall while 0x22 is presented
        @(posedge clk);
        #1;
        send_word(32'h44332211);
        @(posedge clk);
        #1 slave_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_data", {24'd0, sd_l}, 32'h22);
            chk("stall_last", {31'd0, sl_l}, 32'd0);
            chk("stall_valid", {31'd0, sv_l}, 32'd1);
            chk("stall_ready", {31'd0, mr_l}, 32'd0);
            @(posedge clk);
            #1;
        end
        slave_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_resume", {24'd0, sd_l}, 32'h33);
        drain(20);

        // Reset after beat 0x11 retires: the partial word must vanish
        @(posedge clk);
        #1;
        send_word(32'h44332211);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_valid", {31'd0, sv_l}, 32'd0);
        chk("rstmid_valid_msb", {31'd0, sv_m}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(32'h0000BEEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("beef_data", {24'd0, sd_l}, (k == 0) ? 32'hEF : (k == 1) ? 32'hBE : 32'h00);
        end
        drain(20);

        // Random traffic with random valid/ready
        @(posedge clk);
        #1;
        nsent = 0;
        master_valid = 1'b1;
        master_data  = $urandom;
        for (int cyc = 0; cyc < 3000 && nsent < 30; cyc++) begin
            @(negedge clk);
            fired = master_valid && mr_l;
            @(posedge clk);
            #1;
            if (fired) nsent++;
            slave_ready = ($urandom_range(0, 3) != 0);
            if (fired || !master_valid) begin
                master_valid = (nsent < 30) && ($urandom_range(0, 1) == 1);
                master_data  = $urandom;
            end
        end
        master_valid = 1'b0;
        chk("rand_sent", nsent, 32'd30);
        slave_ready = 1'b1;
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
